// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, fault codes, FSM states.
package lsu_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      F_NONE     = 2'b00,
      F_MISALIGN = 2'b01,
      F_RANGE    = 2'b10,
      F_SIZE     = 2'b11
   } fault_e;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RMW_RD,
      WRITE,
      RESP
   } state_e;

   // Big-endian: byte offset k sits at bits [31-8k -: 8], i.e. shifted left by 8*(3-k).
   function automatic logic [4:0] byte_shift(input logic [1:0] off);
      return {~off, 3'b000};
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering between a memory word and sub-word request data (big-endian lanes).
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]        size,
   input  logic [1:0]        off,
   input  logic              is_unsigned,
   input  logic [DATA_W-1:0] word_in,
   input  logic [15:0]       wdata,
   output logic [DATA_W-1:0] ld_data,
   output logic [DATA_W-1:0] st_data
);

   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic [DATA_W-1:0] mask;
   logic [DATA_W-1:0] ins;

   // Extract/extend the addressed lane for loads and build the merged word for stores.
   always_comb begin
      lane_b  = 8'(word_in >> byte_shift(off));
      lane_h  = off[1] ? word_in[15:0] : word_in[31:16];
      ld_data = word_in;
      mask    = '0;
      ins     = '0;
      case (size)
         SZ_B: begin
            ld_data = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
            mask    = 32'h0000_00FF << byte_shift(off);
            ins     = {24'h0, wdata[7:0]} << byte_shift(off);
         end
         SZ_H: begin
            ld_data = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
            mask    = off[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
            ins     = off[1] ? {16'h0, wdata} : {wdata, 16'h0};
         end
         default: ;
      endcase
      st_data = (word_in & ~mask) | ins;
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer in front of data_mem: fault screening, loads, word stores
// and read-modify-write for sub-word stores (data_mem has no byte enables).
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// LOAD   | mem_read on aligned address, result extracted at end of cycle
// RMW_RD | mem_read of the word that a sub-word store will patch
// WRITE  | mem_write of the full or merged word
// RESP   | response held until resp_ready
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int MEM_BYTES = 16384,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic [1:0]        resp_fault,
   output logic [31:0]       mem_address,
   output logic [31:0]       mem_write_data,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [31:0]       mem_read_data
);

   state_e            state_q, state_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [1:0]        off_q, off_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [1:0]        fault_q, fault_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [31:0]       mem_address_q, mem_address_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;

   logic              accept;
   logic [ADDR_W-1:0] req_aligned;
   fault_e            req_fault;
   logic [31:0]       ld_data;
   logic [31:0]       st_data;

   lsu_lane_align u_lane (
      .size        (size_q),
      .off         (off_q),
      .is_unsigned (uns_q),
      .word_in     (mem_read_data),
      .wdata       (wdata_q),
      .ld_data     (ld_data),
      .st_data     (st_data)
   );

   // Reset also blanks the memory strobes combinationally so nothing commits on a reset edge.
   assign req_ready      = (state_q == IDLE) & ~rst;
   assign accept         = req_valid & req_ready;
   assign resp_valid     = resp_valid_q;
   assign resp_rdata     = rdata_q;
   assign resp_fault     = fault_q;
   assign mem_read       = mem_read_q & ~rst;
   assign mem_write      = mem_write_q & ~rst;
   assign mem_address    = rst ? '0 : mem_address_q;
   assign mem_write_data = rst ? '0 : mem_wdata_q;

   // Fault screening of the incoming request, size first, then alignment, then range.
   always_comb begin
      req_aligned = {req_addr[ADDR_W-1:2], 2'b00};
      req_fault   = F_NONE;
      if (req_size == 2'b11) begin
         req_fault = F_SIZE;
      end else if ((req_size == SZ_H && req_addr[0]) ||
                   (req_size == SZ_W && req_addr[1:0] != 2'b00)) begin
         req_fault = F_MISALIGN;
      end else if (req_aligned >= ADDR_W'(MEM_BYTES)) begin
         req_fault = F_RANGE;
      end
   end

   // Next-state and next-output computation for the sequencer.
   always_comb begin
      state_d       = state_q;
      size_d        = size_q;
      uns_d         = uns_q;
      off_d         = off_q;
      wdata_d       = wdata_q;
      resp_valid_d  = resp_valid_q;
      rdata_d       = rdata_q;
      fault_d       = fault_q;
      mem_read_d    = mem_read_q;
      mem_write_d   = mem_write_q;
      mem_address_d = mem_address_q;
      mem_wdata_d   = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               size_d  = req_size;
               uns_d   = req_unsigned;
               off_d   = req_addr[1:0];
               wdata_d = req_wdata[15:0];
               if (req_fault != F_NONE) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  fault_d      = req_fault;
                  rdata_d      = '0;
               end else begin
                  mem_address_d = 32'(req_aligned);
                  if (!req_we) begin
                     state_d    = LOAD;
                     mem_read_d = 1'b1;
                  end else if (req_size == SZ_W) begin
                     state_d     = WRITE;
                     mem_write_d = 1'b1;
                     mem_wdata_d = req_wdata;
                  end else begin
                     state_d    = RMW_RD;
                     mem_read_d = 1'b1;
                  end
               end
            end
         end
         LOAD: begin
            state_d       = RESP;
            rdata_d       = ld_data;
            fault_d       = F_NONE;
            resp_valid_d  = 1'b1;
            mem_read_d    = 1'b0;
            mem_address_d = '0;
         end
         RMW_RD: begin
            state_d     = WRITE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b1;
            mem_wdata_d = st_data;
         end
         WRITE: begin
            state_d       = RESP;
            mem_write_d   = 1'b0;
            mem_address_d = '0;
            mem_wdata_d   = '0;
            rdata_d       = '0;
            fault_d       = F_NONE;
            resp_valid_d  = 1'b1;
         end
         RESP: begin
            if (resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset drops any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         size_q        <= '0;
         uns_q         <= 1'b0;
         off_q         <= '0;
         wdata_q       <= '0;
         resp_valid_q  <= 1'b0;
         rdata_q       <= '0;
         fault_q       <= '0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         size_q        <= size_d;
         uns_q         <= uns_d;
         off_q         <= off_d;
         wdata_q       <= wdata_d;
         resp_valid_q  <= resp_valid_d;
         rdata_q       <= rdata_d;
         fault_q       <= fault_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl with a behavioural data_mem and a response scoreboard.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_fault;
   logic [31:0] mem_address, mem_write_data, mem_read_data;
   logic        mem_write, mem_read;

   lsu_ctrl #(.MEM_BYTES(16384), .ADDR_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_size       (req_size),
      .req_unsigned   (req_unsigned),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_rdata     (resp_rdata),
      .resp_fault     (resp_fault),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_write      (mem_write),
      .mem_read       (mem_read),
      .mem_read_data  (mem_read_data)
   );

   always #5 clk = ~clk;

   // data_mem: combinational read, synchronous write, no byte enables.
   logic [31:0] mem [0:4095];
   assign mem_read_data = mem[mem_address[13:2]];
   always @(posedge clk) if (mem_write) mem[mem_address[13:2]] <= mem_write_data;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  fault;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          first_cyc = 0;
   bit          seen = 1'b0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: memory activity bookkeeping and scoreboard pop on each response handshake.
   always @(negedge clk) begin
      if (mem_read) rd_cnt++;
      if (mem_write) begin
         wr_cnt++;
         wr_addr = mem_address;
         wr_data = mem_write_data;
      end
      if (mem_read && mem_write) chk("mem_rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
      if (rst) begin
         seen = 1'b0;
      end else begin
         if (resp_valid && !seen) begin
            seen      = 1'b1;
            first_cyc = cyc;
         end
         if (!resp_valid) seen = 1'b0;
         if (resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_resp rdata=0x%08h fault=%0d expected=no_response", resp_rdata, resp_fault);
            end else begin
               mon_e = sb.pop_front();
               chk("resp_rdata", resp_rdata, mon_e.rdata);
               chk("resp_fault", 32'(resp_fault), 32'(mon_e.fault));
               chk("resp_latency", 32'(first_cyc - mon_e.acc), 32'(mon_e.lat));
            end
            seen = 1'b0;
         end
      end
   end

   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_fault, input int lat,
                        input int exp_rd, input int exp_wr, input logic [31:0] exp_wdata);
      exp_t e;
      int   n;
      @(negedge clk);
      rd_cnt       = 0;
      wr_cnt       = 0;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      req_valid    = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_before_accept", 32'(req_ready), 32'd1);
      e.rdata = exp_rdata;
      e.fault = exp_fault;
      e.lat   = lat;
      e.acc   = cyc;
      sb.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("resp_received", 32'(sb.size()), 32'd0);
      sb.delete();
      chk("mem_read_cycles", 32'(rd_cnt), 32'(exp_rd));
      chk("mem_write_cycles", 32'(wr_cnt), 32'(exp_wr));
      if (exp_wr != 0) begin
         chk("mem_write_addr", wr_addr, {addr[31:2], 2'b00});
         chk("mem_write_data", wr_data, exp_wdata);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog_timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      exp_t e;
      int   n;
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      resp_ready   = 1'b1;

      repeat (2) begin
         @(negedge clk);
         chk("rst_req_ready", 32'(req_ready), 32'd0);
         chk("rst_resp_valid", 32'(resp_valid), 32'd0);
         chk("rst_mem_read", 32'(mem_read), 32'd0);
         chk("rst_mem_write", 32'(mem_write), 32'd0);
         chk("rst_mem_address", mem_address, 32'd0);
         chk("rst_mem_write_data", mem_write_data, 32'd0);
         chk("rst_resp_rdata", resp_rdata, 32'd0);
         chk("rst_resp_fault", 32'(resp_fault), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_req_ready", 32'(req_ready), 32'd1);

      //     we    size   uns   addr           wdata          rdata          flt    lat rd wr wdata
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h1122_3344, 32'h0,         2'b00, 2, 0, 1, 32'h1122_3344);
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'hCAFE_F00D, 32'h0,         2'b00, 2, 0, 1, 32'hCAFE_F00D);
      issue(1'b1, 2'b10, 1'b0, 32'h0000_3FFC, 32'h5A5A_A5A5, 32'h0,         2'b00, 2, 0, 1, 32'h5A5A_A5A5);
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         32'h1122_3344, 2'b00, 2, 1, 0, 32'h0);
      issue(1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0,         32'h0000_0022, 2'b00, 2, 1, 0, 32'h0);
      issue(1'b1, 2'b00, 1'b0, 32'h0000_0102, 32'h0000_00AB, 32'h0,         2'b00, 3, 1, 1, 32'h1122_AB44);
      issue(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0,         32'hFFFF_AB44, 2'b00, 2, 1, 0, 32'h0);
      issue(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_0080, 32'h0,         2'b00, 3, 1, 1, 32'h1122_AB80);
      issue(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,         32'hFFFF_FF80, 2'b00, 2, 1, 0, 32'h0);
      issue(1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_0011, 2'b00, 2, 1, 0, 32'h0);
      issue(1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0,         32'h0000_1122, 2'b00, 2, 1, 0, 32'h0);
      issue(1'b1, 2'b01, 1'b1, 32'h0000_0100, 32'hFFFF_BEEF, 32'h0,         2'b00, 3, 1, 1, 32'hBEEF_AB80);
      issue(1'b0, 2'b10, 1'b1, 32'h0000_0100, 32'h0,         32'hBEEF_AB80, 2'b00, 2, 1, 0, 32'h0);
      issue(1'b0, 2'b10, 1'b0, 32'h0000_3FFC, 32'h0,         32'h5A5A_A5A5, 2'b00, 2, 1, 0, 32'h0);
      issue(1'b0, 2'b01, 1'b0, 32'h0000_3FFE, 32'h0,         32'hFFFF_A5A5, 2'b00, 2, 1, 0, 32'h0);
      issue(1'b0, 2'b00, 1'b1, 32'h0000_3FFF, 32'h0,         32'h0000_00A5, 2'b00, 2, 1, 0, 32'h0);
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,         32'h0,         2'b01, 1, 0, 0, 32'h0);
      issue(1'b0, 2'b00, 1'b0, 32'h0000_4000, 32'h0,         32'h0,         2'b10, 1, 0, 0, 32'h0);
      issue(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,         32'h0,         2'b11, 1, 0, 0, 32'h0);
      issue(1'b1, 2'b11, 1'b0, 32'h0000_4001, 32'h1234_5678, 32'h0,         2'b11, 1, 0, 0, 32'h0);
      issue(1'b1, 2'b01, 1'b0, 32'h0000_4001, 32'h1234_5678, 32'h0,         2'b01, 1, 0, 0, 32'h0);
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h1234_5678, 32'h0,         2'b01, 1, 0, 0, 32'h0);
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         32'hBEEF_AB80, 2'b00, 2, 1, 0, 32'h0);

      // Response back-pressure: resp_ready low for three RESP cycles.
      @(negedge clk);
      rd_cnt       = 0;
      wr_cnt       = 0;
      resp_ready   = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b10;
      req_unsigned = 1'b0;
      req_addr     = 32'h0000_0100;
      req_valid    = 1'b1;
      chk("stall_req_ready_idle", 32'(req_ready), 32'd1);
      e.rdata = 32'hBEEF_AB80;
      e.fault = 2'b00;
      e.lat   = 2;
      e.acc   = cyc;
      sb.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 3; i++) begin
         chk("stall_resp_valid", 32'(resp_valid), 32'd1);
         chk("stall_resp_rdata", resp_rdata, 32'hBEEF_AB80);
         chk("stall_resp_fault", 32'(resp_fault), 32'd0);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
         chk("stall_mem_idle", 32'(mem_read | mem_write), 32'd0);
         if (i < 2) @(negedge clk);
      end
      @(posedge clk);
      #1 resp_ready = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("stall_resp_received", 32'(sb.size()), 32'd0);
      sb.delete();
      @(negedge clk);
      chk("stall_back_to_idle", 32'(req_ready), 32'd1);
      chk("stall_mem_read_cycles", 32'(rd_cnt), 32'd1);
      chk("stall_mem_write_cycles", 32'(wr_cnt), 32'd0);

      // Reset during RMW_RD of a byte store: no write, no response, memory intact.
      @(negedge clk);
      rd_cnt       = 0;
      wr_cnt       = 0;
      req_we       = 1'b1;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 32'h0000_0104;
      req_wdata    = 32'h0000_0055;
      req_valid    = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rmw_rd_mem_read", 32'(mem_read), 32'd1);
      chk("rmw_rd_mem_address", mem_address, 32'h0000_0104);
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("midrst_req_ready", 32'(req_ready), 32'd0);
         chk("midrst_mem_write", 32'(mem_write), 32'd0);
         chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_req_ready_after", 32'(req_ready), 32'd1);
      chk("midrst_resp_valid_after", 32'(resp_valid), 32'd0);
      chk("midrst_write_cycles", 32'(wr_cnt), 32'd0);
      chk("midrst_mem_word", mem[12'h041], 32'hCAFE_F00D);

      issue(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 2'b00, 2, 1, 0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
